// File: rtl/fg_event_monitor_pkg.sv
// fg_monitor_pkg: shared FSM state type, default sizes and saturating increment for the f/g event monitor
package fg_monitor_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_G, HOLD} state_t;

    localparam int DEF_CNT_W  = 8;
    localparam int DEF_WINDOW = 4;

    // Adds one when en is set, but never past max, so counters stick at full scale
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max, input logic en);
        return (en && v < max) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/fg_event_monitor_if.sv
// fg_event_monitor_if: valid/ready latency-record channel between the monitor and its consumer
interface fg_event_monitor_if #(parameter int LAT_W = 3);

    logic             evt_valid;
    logic             evt_ready;
    logic [LAT_W-1:0] evt_lat;

    modport master(output evt_valid, output evt_lat, input evt_ready);
    modport slave(input evt_valid, input evt_lat, output evt_ready);

endinterface

// File: rtl/fg_rise_det.sv
// fg_rise_det: two-flop input register with a one-cycle rising-edge pulse
module fg_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic x_i,
    output logic rise_o
);

    logic s_q, p_q;

    // Capture the level, then delay it one more cycle to compare against
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 1'b0;
            p_q <= 1'b0;
        end else begin
            s_q <= x_i;
            p_q <= s_q;
        end
    end

    assign rise_o = s_q & ~p_q;

endmodule

// File: rtl/fg_event_monitor.sv
// fg_event_monitor: pairs f rises with the next g rise inside a window and reports latency plus statistics
module fg_event_monitor
    import fg_monitor_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int WINDOW = DEF_WINDOW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_i,
    input  logic                  g_i,
    input  logic                  clr_i,
    fg_event_monitor_if.master    evt,
    output logic [CNT_W-1:0]      f_cnt_o,
    output logic [CNT_W-1:0]      g_cnt_o,
    output logic [CNT_W-1:0]      miss_cnt_o,
    output logic [CNT_W-1:0]      drop_cnt_o,
    output logic                  busy_o
);

    localparam int LAT_W = $clog2(WINDOW + 1);
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic rise_f, rise_g;
    state_t state_q, state_d;
    logic [LAT_W-1:0] timer_q, timer_d, lat_q, lat_d;
    logic [CNT_W-1:0] f_cnt_q, f_cnt_d, g_cnt_q, g_cnt_d, miss_cnt_q, miss_cnt_d, drop_cnt_q, drop_cnt_d;
    logic miss_inc, drop_inc;

    fg_rise_det u_f (.clk(clk), .rst_n(rst_n), .x_i(f_i), .rise_o(rise_f));
    fg_rise_det u_g (.clk(clk), .rst_n(rst_n), .x_i(g_i), .rise_o(rise_g));

    // Pairing FSM: a g rise in WAIT_G closes the pair even on the last window cycle
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        lat_d    = lat_q;
        miss_inc = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_f) begin
                    state_d = WAIT_G;
                    timer_d = LAT_W'(1);
                end
            end
            WAIT_G: begin
                drop_inc = rise_f;
                if (rise_g) begin
                    state_d = HOLD;
                    lat_d   = timer_q;
                end else if (timer_q == LAT_W'(WINDOW)) begin
                    state_d  = IDLE;
                    miss_inc = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HOLD: begin
                if (evt.evt_ready) begin
                    state_d = rise_f ? WAIT_G : IDLE;
                    timer_d = LAT_W'(1);
                end else begin
                    drop_inc = rise_f;
                end
            end
            default: state_d = IDLE;
        endcase
        f_cnt_d    = CNT_W'(sat_inc(32'(f_cnt_q), CNT_MAX, rise_f));
        g_cnt_d    = CNT_W'(sat_inc(32'(g_cnt_q), CNT_MAX, rise_g));
        miss_cnt_d = CNT_W'(sat_inc(32'(miss_cnt_q), CNT_MAX, miss_inc));
        drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_MAX, drop_inc));
    end

    // State and statistics registers; clr wipes everything except the input edge detectors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            lat_q      <= '0;
            f_cnt_q    <= '0;
            g_cnt_q    <= '0;
            miss_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else if (clr_i) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            lat_q      <= '0;
            f_cnt_q    <= '0;
            g_cnt_q    <= '0;
            miss_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lat_q      <= lat_d;
            f_cnt_q    <= f_cnt_d;
            g_cnt_q    <= g_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign evt.evt_valid = (state_q == HOLD);
    assign evt.evt_lat   = lat_q;
    assign busy_o        = (state_q != IDLE);
    assign f_cnt_o       = f_cnt_q;
    assign g_cnt_o       = g_cnt_q;
    assign miss_cnt_o    = miss_cnt_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_fg_event_monitor.sv
// tb_fg_event_monitor: directed checks of pairing, window expiry, back-pressure, saturation, reset and clear
module tb_fg_event_monitor;

    logic clk = 1'b0;
    logic rst_n, f, g, clr, ready;
    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] a_f, a_g, a_miss, a_drop;
    logic [2:0] b_f, b_g, b_miss, b_drop;
    logic a_busy, b_busy;

    fg_event_monitor_if #(.LAT_W(3)) bus_a ();
    fg_event_monitor_if #(.LAT_W(3)) bus_b ();

    assign bus_a.evt_ready = ready;
    assign bus_b.evt_ready = ready;

    fg_event_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .f_i(f), .g_i(g), .clr_i(clr), .evt(bus_a),
        .f_cnt_o(a_f), .g_cnt_o(a_g), .miss_cnt_o(a_miss), .drop_cnt_o(a_drop), .busy_o(a_busy)
    );

    fg_event_monitor #(.CNT_W(3), .WINDOW(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .f_i(f), .g_i(g), .clr_i(clr), .evt(bus_b),
        .f_cnt_o(b_f), .g_cnt_o(b_g), .miss_cnt_o(b_miss), .drop_cnt_o(b_drop), .busy_o(b_busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(a_busy), 0);
        chk({tag, "_valid"}, 32'(bus_a.evt_valid), 0);
    endtask

    initial begin
        rst_n = 1'b0; f = 1'b0; g = 1'b0; clr = 1'b0; ready = 1'b0;
        // 1: reset, then quiet inputs
        tick(3);
        chk("rst_valid", 32'(bus_a.evt_valid), 0);
        chk("rst_lat", 32'(bus_a.evt_lat), 0);
        chk("rst_fcnt", 32'(a_f), 0);
        chk("rst_busy", 32'(a_busy), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_idle("quiet");
            chk("quiet_cnts", 32'(a_f) + 32'(a_g) + 32'(a_miss) + 32'(a_drop), 0);
        end
        // 2: f then g two cycles later, consumer ready
        ready = 1'b1; f = 1'b1;
        tick(2);
        chk("p_busy", 32'(a_busy), 1);
        chk("p_fcnt", 32'(a_f), 1);
        g = 1'b1;
        tick(1);
        chk("p_valid_early", 32'(bus_a.evt_valid), 0);
        chk("p_gcnt_early", 32'(a_g), 0);
        tick(1);
        chk("p_valid", 32'(bus_a.evt_valid), 1);
        chk("p_lat", 32'(bus_a.evt_lat), 2);
        chk("p_gcnt", 32'(a_g), 1);
        tick(1);
        chk_idle("p_done");
        chk("p_miss", 32'(a_miss), 0);
        f = 1'b0; g = 1'b0;
        tick(3);
        // 3: f without g expires after WINDOW cycles
        f = 1'b1;
        tick(2);
        chk("m_busy", 32'(a_busy), 1);
        tick(3);
        chk("m_busy_late", 32'(a_busy), 1);
        chk("m_miss_early", 32'(a_miss), 0);
        tick(1);
        chk_idle("m_done");
        chk("m_miss", 32'(a_miss), 1);
        f = 1'b0;
        tick(3);
        // 4: back-pressure with a second f rise during HOLD
        ready = 1'b0; f = 1'b1;
        tick(2);
        g = 1'b1;
        tick(2);
        chk("h_valid", 32'(bus_a.evt_valid), 1);
        chk("h_lat", 32'(bus_a.evt_lat), 2);
        f = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            chk("h_valid_hold", 32'(bus_a.evt_valid), 1);
        end
        f = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            chk("h_valid_hold2", 32'(bus_a.evt_valid), 1);
            chk("h_lat_hold", 32'(bus_a.evt_lat), 2);
        end
        chk("h_drop", 32'(a_drop), 1);
        ready = 1'b1;
        tick(1);
        chk_idle("h_acc");
        chk("h_fcnt", 32'(a_f), 4);
        chk("h_gcnt", 32'(a_g), 2);
        chk("h_drop_after", 32'(a_drop), 1);
        f = 1'b0; g = 1'b0;
        tick(3);
        // 5: saturation on the 3-bit instance
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("c_fcnt", 32'(a_f), 0);
        chk("c_sat_fcnt", 32'(b_f), 0);
        for (int i = 0; i < 9; i++) begin
            f = 1'b1;
            tick(4);
            f = 1'b0;
            tick(4);
            if (i == 6) chk("s_f7", 32'(b_f), 7);
        end
        chk("s_fcnt", 32'(b_f), 7);
        chk("s_miss", 32'(b_miss), 7);
        chk("s_wide_fcnt", 32'(a_f), 9);
        chk("s_wide_miss", 32'(a_miss), 9);
        chk("s_busy", 32'(b_busy), 0);
        // 6a: async reset while waiting for g
        f = 1'b1;
        tick(2);
        chk("r_busy", 32'(a_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("r_busy_async", 32'(a_busy), 0);
        chk("r_fcnt_async", 32'(a_f), 0);
        f = 1'b0;
        tick(1);
        chk_idle("r_next");
        chk("r_miss", 32'(a_miss), 0);
        rst_n = 1'b1;
        tick(3);
        // 6b: clear while holding a record
        ready = 1'b0; f = 1'b1;
        tick(2);
        g = 1'b1;
        tick(2);
        chk("k_valid", 32'(bus_a.evt_valid), 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk_idle("k_clr");
        chk("k_cnts", 32'(a_f) + 32'(a_g) + 32'(a_miss) + 32'(a_drop), 0);
        f = 1'b0; g = 1'b0;
        tick(3);
        chk_idle("k_after");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
